// File: rtl/calc_arbiter.sv
// -----------------------------------------------------------------------------
// calc_arbiter
//   Shares one calculator datapath among N_REQ requesters. One operation is
//   accepted at a time, its operands and function code are presented to the
//   calculator, the result is captured after CALC_LAT cycles and returned on a
//   single tagged response channel.
//
// Build option:
//   CALC_ARB_FIXED_PRIO_EN  defined   -> fixed priority, requester 0 highest,
//                                        no round-robin pointer.
//                           undefined -> round-robin arbitration (default).
//
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero, combinational in IDLE)
//   req_a/b    per-requester 8-bit operands, lane i at [8i+7:8i]
//   req_fn     per-requester 2-bit function code, lane i at [2i+1:2i]
//   calc_a/b   operands driven to the calculator (held between operations)
//   calc_fn    function code driven to the calculator
//   calc_out   16-bit calculator result
//   rsp_valid  response valid, held until rsp_ready
//   rsp_ready  response consumer ready
//   rsp_id     requester index owning the response
//   rsp_data   captured calculator result
//   busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module calc_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CALC_LAT = 1,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  input  logic [2*N_REQ-1:0]   req_fn,
  output logic [7:0]           calc_a,
  output logic [7:0]           calc_b,
  output logic [1:0]           calc_fn,
  input  logic [15:0]          calc_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 busy
);

  localparam int LW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(CALC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [LW-1:0]   lat_cnt_q;
  logic [7:0]      calc_a_q;
  logic [7:0]      calc_b_q;
  logic [1:0]      calc_fn_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [15:0]     rsp_data_q;
  logic            busy_q;

  logic            win_vld_s;
  logic [IDW-1:0]  win_idx_s;
  logic [IDW-1:0]  cand_s;
  logic [7:0]      sel_a_s;
  logic [7:0]      sel_b_s;
  logic [1:0]      sel_fn_s;

`ifndef CALC_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
`endif

  // Winner search: first set req_valid bit from the search start, wrapping.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = '0;
    cand_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef CALC_ARB_FIXED_PRIO_EN
      cand_s = IDW'(k);
`else
      cand_s = IDW'((int'(rr_ptr_q) + k) % N_REQ);
`endif
      if (!win_vld_s && req_valid[cand_s]) begin
        win_vld_s = 1'b1;
        win_idx_s = cand_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Operand mux for the winning lane.
  always_comb begin
    sel_a_s  = 8'h00;
    sel_b_s  = 8'h00;
    sel_fn_s = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx_s == IDW'(i)) begin
        sel_a_s  = req_a[8*i +: 8];
        sel_b_s  = req_b[8*i +: 8];
        sel_fn_s = req_fn[2*i +: 2];
      end else begin
        sel_a_s  = sel_a_s;
      end
    end
  end

`ifndef CALC_ARB_FIXED_PRIO_EN
  // Pointer moves one past the winner so the winner becomes lowest priority.
  always_comb begin
    if (win_idx_s == IDW'(N_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = win_idx_s + 1'b1;
    end
  end
`endif

  // Grant is combinational so the handshake completes on the accept edge.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == IDLE) && win_vld_s) begin
      req_ready[win_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Sequencer FSM with registered datapath and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      calc_a_q    <= 8'h00;
      calc_b_q    <= 8'h00;
      calc_fn_q   <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 16'h0000;
      busy_q      <= 1'b0;
`ifndef CALC_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_s) begin
            calc_a_q  <= sel_a_s;
            calc_b_q  <= sel_b_s;
            calc_fn_q <= sel_fn_s;
            rsp_id_q  <= win_idx_s;
            lat_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= EXEC;
`ifndef CALC_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
          end
        end
        EXEC: begin
          // calc_* stay untouched here so the calculator sees stable inputs.
          if (lat_cnt_q == LAT_LAST) begin
            rsp_data_q  <= calc_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign calc_a    = calc_a_q;
  assign calc_b    = calc_b_q;
  assign calc_fn   = calc_fn_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule
